// File: rtl/vlc_packer.sv
// N-channel MSB-first code merger and JPEG byte packer with 0xFF stuffing and a show-ahead byte FIFO.
// Optional statistics outputs (byte_count, stuff_count) are enabled by defining VLC_PACKER_STATS_EN.
module vlc_packer #(
  parameter int NCH        = 4,
  parameter int MAXLEN     = 32,
  parameter int FIFO_DEPTH = 64,
  parameter bit PAD_BIT    = 1'b1,
  localparam int LW  = $clog2(MAXLEN + 1),
  localparam int ACC = 2 * MAXLEN,
  localparam int CW  = $clog2(2 * MAXLEN + 1),
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int LVW = AW + 1,
  localparam int WW  = MAXLEN + 7,
  localparam int IW  = NCH * (LW + MAXLEN + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*LW-1:0]     in_len,
  input  logic [NCH*MAXLEN-1:0] in_data,
  input  logic [NCH-1:0]        in_raw,
  input  logic                  in_align,
  output logic                  in_ready,
  output logic                  ready,
  input  logic                  dequeue,
  output logic [7:0]            jpeg,
  output logic [LVW-1:0]        level,
  output logic                  collision,
  output logic                  overflow,
  output logic                  misalign
`ifdef VLC_PACKER_STATS_EN
  ,
  output logic [31:0]           byte_count,
  output logic [15:0]           stuff_count
`endif
);

  // Accumulator is MSB-aligned: acc[ACC-1] is the next bit to leave; bits below cnt are zero.
  logic [ACC-1:0] acc, tag;
  logic [CW-1:0]  cnt;
  logic           stuff_pending;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           stall_q;
  logic [IW-1:0]  prev_in;

  logic [LW-1:0]     sel_len;
  logic [MAXLEN-1:0] sel_data;
  logic              sel_raw, found, multi, req, accept, raw_ok;
  logic [2:0]        pad;
  logic [CW-1:0]     new_len, rem, cnt_n;
  logic [WW-1:0]     len_mask, pad_mask, code_w, tag_w;
  logic [ACC-1:0]    code_l, tagl, base_acc, base_tag, acc_n, tag_n;
  logic              full, wr_en, rd_en, pop_bits, sp_n, in_ready_n, ovf_set;
  logic [7:0]        wr_byte;
  logic [LVW-1:0]    level_n;
  logic [IW-1:0]     cur_in;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel_len  = '0;
    sel_data = '0;
    sel_raw  = 1'b0;
    found    = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_len[i*LW +: LW] != '0) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found    = 1'b1;
          sel_len  = in_len[i*LW +: LW];
          sel_data = in_data[i*MAXLEN +: MAXLEN];
          sel_raw  = in_raw[i];
        end
      end
    end
  end

  assign cur_in = {in_len, in_data, in_raw, in_align};
  assign req    = found || in_align;
  assign accept = in_ready && req;
  // A raw code keeps its tag only when it starts and ends on a byte boundary.
  assign raw_ok = sel_raw && (cnt[2:0] == 3'd0) && (sel_len[2:0] == 3'd0);
  // A request that changes while stalled was never held, so its predecessor is lost.
  assign ovf_set = !in_ready && req && stall_q && (cur_in != prev_in);

  always_comb begin
    pad      = in_align ? (3'd0 - (cnt[2:0] + sel_len[2:0])) : 3'd0;
    len_mask = ~({WW{1'b1}} << sel_len);
    pad_mask = ~({WW{1'b1}} << pad);
    code_w   = '0;
    tag_w    = '0;
    new_len  = '0;
    if (accept) begin
      new_len = CW'(sel_len) + CW'(pad);
      code_w  = ((WW'(sel_data) & len_mask) << pad) | (PAD_BIT ? pad_mask : '0);
      tag_w   = raw_ok ? (len_mask << pad) : '0;
    end
    code_l = {code_w, {(ACC-WW){1'b0}}} << (CW'(WW) - new_len);
    tagl   = {tag_w,  {(ACC-WW){1'b0}}} << (CW'(WW) - new_len);
  end

  always_comb begin
    full     = (level == LVW'(FIFO_DEPTH));
    wr_en    = 1'b0;
    wr_byte  = 8'h00;
    pop_bits = 1'b0;
    sp_n     = stuff_pending;
    if (!full) begin
      if (stuff_pending) begin
        wr_en = 1'b1;
        sp_n  = 1'b0;
      end else if (cnt >= CW'(8)) begin
        wr_en    = 1'b1;
        pop_bits = 1'b1;
        wr_byte  = acc[ACC-1 -: 8];
        if (acc[ACC-1 -: 8] == 8'hFF && !tag[ACC-1]) sp_n = 1'b1;
      end
    end
    base_acc   = pop_bits ? (acc << 8) : acc;
    base_tag   = pop_bits ? (tag << 8) : tag;
    rem        = pop_bits ? (cnt - CW'(8)) : cnt;
    acc_n      = base_acc | (code_l >> rem);
    tag_n      = base_tag | (tagl >> rem);
    cnt_n      = rem + new_len;
    rd_en      = dequeue && (level != '0);
    level_n    = level + LVW'(wr_en) - LVW'(rd_en);
    in_ready_n = (cnt_n <= CW'(ACC - WW)) && (level_n <= LVW'(FIFO_DEPTH - 2));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      tag           <= '0;
      cnt           <= '0;
      stuff_pending <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      in_ready      <= 1'b1;
      collision     <= 1'b0;
      overflow      <= 1'b0;
      misalign      <= 1'b0;
      stall_q       <= 1'b0;
      prev_in       <= '0;
    end else begin
      acc           <= acc_n;
      tag           <= tag_n;
      cnt           <= cnt_n;
      stuff_pending <= sp_n;
      level         <= level_n;
      in_ready      <= in_ready_n;
      stall_q       <= !in_ready && req;
      prev_in       <= cur_in;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (accept && multi) collision <= 1'b1;
      if (accept && sel_raw && !raw_ok) misalign <= 1'b1;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // NOTE: the byte storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  assign ready = (level != '0);
  assign jpeg  = ready ? mem[rd_ptr] : 8'h00;

`ifdef VLC_PACKER_STATS_EN
  logic frame_start;
  assign frame_start = accept && in_align && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      byte_count  <= '0;
      stuff_count <= '0;
    end else begin
      if (wr_en) byte_count <= byte_count + 32'd1;
      if (wr_en && stuff_pending && stuff_count != 16'hFFFF) stuff_count <= stuff_count + 16'd1;
    end
  end
`endif

endmodule
